// File: rtl/date_jump_ct.sv
// Month/day calendar counter with single-day steps, validated loads and a
// multi-cycle N-day jump that advances one day per clock.
module date_jump_ct #(
  parameter int NW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          ld,
  input  logic [6:0]    ld_mo,
  input  logic [6:0]    ld_dy,
  input  logic          req,
  input  logic          dir,
  input  logic [NW-1:0] n_days,
  output logic [6:0]    mo,
  output logic [6:0]    dy,
  output logic          z_last,
  output logic          z_first,
  output logic          busy,
  output logic          done,
  output logic          yr_cy,
  output logic          yr_bw,
  output logic          ld_err
);

  typedef enum logic {IDLE, JUMP} state_t;

  state_t        state_q, state_d;
  logic [6:0]    mo_q, mo_d;
  logic [6:0]    dy_q, dy_d;
  logic          dir_q, dir_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          yr_cy_q, yr_cy_d;
  logic          yr_bw_q, yr_bw_d;
  logic          ld_err_q, ld_err_d;

  logic [6:0]    cur_len;
  logic [6:0]    fwd_mo, fwd_dy, bwd_mo, bwd_dy;
  logic          fwd_cy, bwd_bw;
  logic          ld_ok;

  function automatic logic [6:0] month_len(input logic [6:0] m);
    case (m)
      7'd1:                      month_len = 7'd28;
      7'd3, 7'd5, 7'd8, 7'd10:   month_len = 7'd30;
      default:                   month_len = 7'd31;
    endcase
  endfunction

  assign cur_len = month_len(mo_q);
  assign ld_ok   = (ld_mo < 7'd12) && (ld_dy < month_len(ld_mo));

  // Candidate next dates for one step in each direction, shared by IDLE and JUMP.
  always_comb begin
    fwd_mo = mo_q;
    fwd_dy = dy_q + 7'd1;
    fwd_cy = 1'b0;
    if (dy_q == cur_len - 7'd1) begin
      fwd_dy = 7'd0;
      fwd_mo = (mo_q == 7'd11) ? 7'd0 : mo_q + 7'd1;
      fwd_cy = (mo_q == 7'd11);
    end

    bwd_mo = mo_q;
    bwd_dy = dy_q - 7'd1;
    bwd_bw = 1'b0;
    if (dy_q == 7'd0) begin
      bwd_mo = (mo_q == 7'd0) ? 7'd11 : mo_q - 7'd1;
      bwd_dy = month_len(bwd_mo) - 7'd1;
      bwd_bw = (mo_q == 7'd0);
    end
  end

  always_comb begin
    state_d  = state_q;
    mo_d     = mo_q;
    dy_d     = dy_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    yr_cy_d  = 1'b0;
    yr_bw_d  = 1'b0;
    ld_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld) begin
          if (ld_ok) begin
            mo_d = ld_mo;
            dy_d = ld_dy;
          end else begin
            ld_err_d = 1'b1;
          end
        end else if (req) begin
          if (n_days == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = JUMP;
            dir_d   = dir;
            cnt_d   = n_days;
          end
        end else if (inc && !dec) begin
          mo_d    = fwd_mo;
          dy_d    = fwd_dy;
          yr_cy_d = fwd_cy;
        end else if (dec && !inc) begin
          mo_d    = bwd_mo;
          dy_d    = bwd_dy;
          yr_bw_d = bwd_bw;
        end
      end
      JUMP: begin
        // Loads cannot be honoured mid-jump, so they are flagged rather than dropped silently.
        ld_err_d = ld;
        if (dir_q) begin
          mo_d    = fwd_mo;
          dy_d    = fwd_dy;
          yr_cy_d = fwd_cy;
        end else begin
          mo_d    = bwd_mo;
          dy_d    = bwd_dy;
          yr_bw_d = bwd_bw;
        end
        cnt_d = cnt_q - NW'(1);
        if (cnt_q == NW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      mo_q     <= 7'd0;
      dy_q     <= 7'd0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      yr_cy_q  <= 1'b0;
      yr_bw_q  <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mo_q     <= mo_d;
      dy_q     <= dy_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      yr_cy_q  <= yr_cy_d;
      yr_bw_q  <= yr_bw_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign mo      = mo_q;
  assign dy      = dy_q;
  assign z_last  = (dy_q == cur_len - 7'd1);
  assign z_first = (dy_q == 7'd0);
  assign busy    = (state_q == JUMP);
  assign done    = done_q;
  assign yr_cy   = yr_cy_q;
  assign yr_bw   = yr_bw_q;
  assign ld_err  = ld_err_q;

endmodule

// File: tb/tb_date_jump_ct.sv
// Directed self-checking bench for date_jump_ct: steps, year wrap, loads,
// forward/backward jumps and reset during a jump.
module tb_date_jump_ct;

  localparam int NW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          inc, dec, ld, req, dir;
  logic [6:0]    ld_mo, ld_dy;
  logic [NW-1:0] n_days;
  logic [6:0]    mo, dy;
  logic          z_last, z_first, busy, done, yr_cy, yr_bw, ld_err;

  int checks = 0;
  int errors = 0;
  int busy_cycles, cy_count, bw_count;
  bit done_seen;

  date_jump_ct #(.NW(NW)) dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .ld(ld), .ld_mo(ld_mo),
    .ld_dy(ld_dy), .req(req), .dir(dir), .n_days(n_days), .mo(mo), .dy(dy),
    .z_last(z_last), .z_first(z_first), .busy(busy), .done(done),
    .yr_cy(yr_cy), .yr_bw(yr_bw), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inc = 0; dec = 0; ld = 0; req = 0; dir = 0;
    ld_mo = 0; ld_dy = 0; n_days = 0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_date(input string tag, input int m, input int d);
    check_output({tag, ".mo"}, 32'(mo), 32'(m));
    check_output({tag, ".dy"}, 32'(dy), 32'(d));
  endtask

  task automatic load(input int m, input int d);
    ld = 1; ld_mo = 7'(m); ld_dy = 7'(d);
    tick();
    ld = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    tick();
    rst = 1;
    check_date("reset0", 0, 0);
    check_output("reset0.busy", 32'(busy), 0);

    // T1: reset in the middle of activity
    load(5, 10);
    inc = 1; tick(); inc = 0;
    check_date("pre_rst", 5, 11);
    inc = 1; rst = 0; tick(); rst = 1; inc = 0;
    check_date("T1", 0, 0);
    check_output("T1.busy", 32'(busy), 0);
    check_output("T1.pulses", {28'd0, done, yr_cy, yr_bw, ld_err}, 0);

    // T2: month-length-aware single steps
    load(1, 27);
    check_date("T2.ld", 1, 27);
    check_output("T2.zlast", 32'(z_last), 1);
    inc = 1; tick(); inc = 0;
    check_date("T2.inc", 2, 0);
    check_output("T2.zfirst", 32'(z_first), 1);
    dec = 1; tick(); dec = 0;
    check_date("T2.dec", 1, 27);
    load(4, 0);
    dec = 1; tick(); dec = 0;
    check_date("T2.dec_apr", 3, 29);
    inc = 1; dec = 1; tick(); inc = 0; dec = 0;
    check_date("T2.incdec", 3, 29);

    // T3: year borrow and carry
    load(0, 0);
    dec = 1; tick(); dec = 0;
    check_date("T3.dec", 11, 30);
    check_output("T3.yr_bw", 32'(yr_bw), 1);
    tick();
    check_output("T3.yr_bw_off", 32'(yr_bw), 0);
    inc = 1; tick(); inc = 0;
    check_date("T3.inc", 0, 0);
    check_output("T3.yr_cy", 32'(yr_cy), 1);
    tick();
    check_output("T3.yr_cy_off", 32'(yr_cy), 0);

    // Zero-length jump completes immediately
    req = 1; dir = 1; n_days = 0; tick(); req = 0;
    check_output("Z.done", 32'(done), 1);
    check_output("Z.busy", 32'(busy), 0);
    check_date("Z", 0, 0);

    // T4: forward 365-day jump
    req = 1; dir = 1; n_days = 365; tick(); req = 0; dir = 0; n_days = 0;
    check_output("T4.busy0", 32'(busy), 1);
    busy_cycles = 1; cy_count = 0; done_seen = 0;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      tick();
      if (busy) busy_cycles++;
      if (yr_cy) cy_count++;
      if (done) done_seen = 1;
    end
    check_output("T4.done", 32'(done_seen), 1);
    check_output("T4.busy_cycles", 32'(busy_cycles), 365);
    check_output("T4.yr_cy_count", 32'(cy_count), 1);
    check_date("T4.end", 0, 0);
    tick();
    check_output("T4.done_off", 32'(done), 0);

    // T5: rejected and accepted loads
    load(1, 28);
    check_output("T5.err1", 32'(ld_err), 1);
    check_date("T5.keep1", 0, 0);
    load(12, 0);
    check_output("T5.err2", 32'(ld_err), 1);
    check_date("T5.keep2", 0, 0);
    load(10, 29);
    check_output("T5.err3", 32'(ld_err), 0);
    check_date("T5.ld", 10, 29);
    check_output("T5.zlast", 32'(z_last), 1);

    // T6: backward 40-day jump across the year, with a load attempted mid-jump
    load(1, 5);
    req = 1; dir = 0; n_days = 40; tick(); req = 0; n_days = 0;
    tick(); tick();
    check_date("T6.step2", 1, 3);
    ld = 1; ld_mo = 5; ld_dy = 5; tick(); ld = 0;
    check_output("T6.ld_err", 32'(ld_err), 1);
    check_date("T6.step3", 1, 2);
    bw_count = 0; done_seen = 0;
    for (int i = 0; i < 60 && !done_seen; i++) begin
      tick();
      if (yr_bw) bw_count++;
      if (done) done_seen = 1;
    end
    check_output("T6.done", 32'(done_seen), 1);
    check_output("T6.yr_bw_count", 32'(bw_count), 1);
    check_date("T6.end", 11, 27);

    // T6b: reset aborts a jump after ten steps
    load(1, 5);
    req = 1; dir = 0; n_days = 40; tick(); req = 0; n_days = 0;
    for (int i = 0; i < 10; i++) tick();
    check_date("T6b.step10", 0, 26);
    rst = 0; tick(); rst = 1;
    check_date("T6b.rst", 0, 0);
    check_output("T6b.busy", 32'(busy), 0);
    check_output("T6b.done", 32'(done), 0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen = 1;
    end
    check_output("T6b.no_done", 32'(done_seen), 0);
    check_date("T6b.hold", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
